// File: rtl/memory_mc.sv
// Multi-channel timed memory: one write channel plus READ_CHANNELS read channels over one array,
// with a WORD_INIT sweep after reset. Define MEMORY_MC_BYPASS_EN to forward same-edge write data to reads.
module memory_mc #(
    parameter int                   WORD_SIZE     = 8,
    parameter logic [WORD_SIZE-1:0] WORD_INIT     = '0,
    parameter int                   ADDRESS_SIZE  = 4,
    parameter int                   MEMORY_QTY    = 16,
    parameter int                   READ_CHANNELS = 2,
    parameter int                   DELAY_SIZE    = 4,
    parameter int                   READ_LATENCY  = 1,
    parameter int                   WRITE_LATENCY = 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  w_req,
    input  logic [ADDRESS_SIZE-1:0]               w_addr,
    input  logic [WORD_SIZE-1:0]                  w_data,
    output logic                                  w_busy,
    output logic                                  w_ack,
    input  logic [READ_CHANNELS-1:0]              r_req,
    input  logic [READ_CHANNELS*ADDRESS_SIZE-1:0] r_addr,
    output logic [READ_CHANNELS*WORD_SIZE-1:0]    r_data,
    output logic [READ_CHANNELS-1:0]              r_busy,
    output logic [READ_CHANNELS-1:0]              r_ack,
    output logic                                  init_done
);

    // Handshake: a request is accepted on a rising edge where the channel is idle and init is done;
    // busy stays high for LATENCY cycles, then ack pulses for one cycle with busy already low.
    localparam int                    SW     = ADDRESS_SIZE + 1;
    localparam logic [SW-1:0]         QTY    = SW'(MEMORY_QTY);
    localparam logic [DELAY_SIZE-1:0] W_LOAD = DELAY_SIZE'(WRITE_LATENCY - 1);
    localparam logic [DELAY_SIZE-1:0] R_LOAD = DELAY_SIZE'(READ_LATENCY - 1);

    typedef enum logic {W_IDLE, W_WAIT} w_state_t;
    typedef enum logic {R_IDLE, R_WAIT} r_state_t;

    logic [WORD_SIZE-1:0] mem_q [MEMORY_QTY];

    logic [SW-1:0] sweep_q, sweep_d;
    logic          init_done_q, init_done_d;
    logic          sweep_we;

    w_state_t              w_state_q, w_state_d;
    logic [DELAY_SIZE-1:0] w_cnt_q, w_cnt_d;
    logic                  w_ack_q, w_ack_d;
    logic                  w_accept, w_in_range;

    r_state_t              r_state_q [READ_CHANNELS];
    r_state_t              r_state_d [READ_CHANNELS];
    logic [DELAY_SIZE-1:0] r_cnt_q   [READ_CHANNELS];
    logic [DELAY_SIZE-1:0] r_cnt_d   [READ_CHANNELS];
    logic [WORD_SIZE-1:0]  r_hold_q  [READ_CHANNELS];
    logic [WORD_SIZE-1:0]  r_hold_d  [READ_CHANNELS];
    logic [WORD_SIZE-1:0]  r_data_q  [READ_CHANNELS];
    logic [WORD_SIZE-1:0]  r_data_d  [READ_CHANNELS];
    logic [READ_CHANNELS-1:0] r_ack_q, r_ack_d;
    logic [ADDRESS_SIZE-1:0]  r_addr_c [READ_CHANNELS];
    logic [READ_CHANNELS-1:0] r_in_range;

    always_comb begin
        sweep_d     = sweep_q;
        init_done_d = init_done_q;
        sweep_we    = 1'b0;
        if (!init_done_q) begin
            if (sweep_q < QTY) begin
                sweep_we = 1'b1;
                sweep_d  = sweep_q + 1'b1;
            end else begin
                init_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d  = w_state_q;
        w_cnt_d    = w_cnt_q;
        w_ack_d    = 1'b0;
        w_accept   = 1'b0;
        w_in_range = ({1'b0, w_addr} < QTY);
        case (w_state_q)
            W_IDLE: begin
                if (init_done_q && w_req) begin
                    w_accept  = 1'b1;
                    w_cnt_d   = W_LOAD;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == '0) begin
                    w_state_d = W_IDLE;
                    w_ack_d   = 1'b1;
                end else begin
                    w_cnt_d = w_cnt_q - 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        for (int c = 0; c < READ_CHANNELS; c++) begin
            r_addr_c[c]   = r_addr[c*ADDRESS_SIZE +: ADDRESS_SIZE];
            r_in_range[c] = ({1'b0, r_addr_c[c]} < QTY);
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_hold_d  = r_hold_q;
        r_data_d  = r_data_q;
        r_ack_d   = '0;
        for (int c = 0; c < READ_CHANNELS; c++) begin
            case (r_state_q[c])
                R_IDLE: begin
                    if (init_done_q && r_req[c]) begin
                        r_state_d[c] = R_WAIT;
                        r_cnt_d[c]   = R_LOAD;
                        r_hold_d[c]  = r_in_range[c] ? mem_q[r_addr_c[c]] : WORD_INIT;
`ifdef MEMORY_MC_BYPASS_EN
                        if (w_accept && w_in_range && (r_addr_c[c] == w_addr))
                            r_hold_d[c] = w_data;
`endif
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q[c] == '0) begin
                        r_state_d[c] = R_IDLE;
                        r_ack_d[c]   = 1'b1;
                        r_data_d[c]  = r_hold_q[c];
                    end else begin
                        r_cnt_d[c] = r_cnt_q[c] - 1'b1;
                    end
                end
                default: r_state_d[c] = R_IDLE;
            endcase
        end
    end

    // The sweep and the write channel never overlap: writes are only accepted after init_done.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (sweep_we)
                mem_q[sweep_q[ADDRESS_SIZE-1:0]] <= WORD_INIT;
            else if (w_accept && w_in_range)
                mem_q[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            w_state_q   <= W_IDLE;
            w_cnt_q     <= '0;
            w_ack_q     <= 1'b0;
            r_ack_q     <= '0;
            for (int c = 0; c < READ_CHANNELS; c++) begin
                r_state_q[c] <= R_IDLE;
                r_cnt_q[c]   <= '0;
                r_hold_q[c]  <= '0;
                r_data_q[c]  <= '0;
            end
        end else begin
            sweep_q     <= sweep_d;
            init_done_q <= init_done_d;
            w_state_q   <= w_state_d;
            w_cnt_q     <= w_cnt_d;
            w_ack_q     <= w_ack_d;
            r_ack_q     <= r_ack_d;
            r_state_q   <= r_state_d;
            r_cnt_q     <= r_cnt_d;
            r_hold_q    <= r_hold_d;
            r_data_q    <= r_data_d;
        end
    end

    always_comb begin
        r_data = '0;
        r_busy = '0;
        for (int c = 0; c < READ_CHANNELS; c++) begin
            r_data[c*WORD_SIZE +: WORD_SIZE] = r_data_q[c];
            r_busy[c] = (r_state_q[c] == R_WAIT) | ~init_done_q;
        end
    end

    assign w_busy    = (w_state_q == W_WAIT) | ~init_done_q;
    assign w_ack     = w_ack_q;
    assign r_ack     = r_ack_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_memory_mc.sv
// Bench for memory_mc: a 16-word instance and a 12-word instance share stimulus; read data is
// scored against per-channel expected queues, timing corners are checked by hand-written sequences.
module tb_memory_mc;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        w_req = 1'b0;
    logic [3:0]  w_addr = '0;
    logic [7:0]  w_data = '0;
    logic [1:0]  r_req = '0;
    logic [7:0]  r_addr = '0;

    logic        m_w_busy, m_w_ack, m_init_done;
    logic [1:0]  m_r_busy, m_r_ack;
    logic [15:0] m_r_data;
    logic        o_w_busy, o_w_ack, o_init_done;
    logic [1:0]  o_r_busy, o_r_ack;
    logic [15:0] o_r_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mq0[$], mq1[$], oq0[$], oq1[$];
    logic [7:0] mm [16];
    logic [7:0] mo [16];

    typedef struct {
        logic       wr;
        logic [1:0] mask;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [7:0] data;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;
    vec_t vecs [14];

    always #5 clock = ~clock;

    memory_mc #(
        .WORD_SIZE(8), .WORD_INIT(8'hA5), .ADDRESS_SIZE(4), .MEMORY_QTY(16),
        .READ_CHANNELS(2), .DELAY_SIZE(4), .READ_LATENCY(2), .WRITE_LATENCY(3)
    ) u_main (
        .clock(clock), .reset_n(reset_n), .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
        .w_busy(m_w_busy), .w_ack(m_w_ack), .r_req(r_req), .r_addr(r_addr), .r_data(m_r_data),
        .r_busy(m_r_busy), .r_ack(m_r_ack), .init_done(m_init_done)
    );

    memory_mc #(
        .WORD_SIZE(8), .WORD_INIT(8'hA5), .ADDRESS_SIZE(4), .MEMORY_QTY(12),
        .READ_CHANNELS(2), .DELAY_SIZE(4), .READ_LATENCY(2), .WRITE_LATENCY(3)
    ) u_oor (
        .clock(clock), .reset_n(reset_n), .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
        .w_busy(o_w_busy), .w_ack(o_w_ack), .r_req(r_req), .r_addr(r_addr), .r_data(o_r_data),
        .r_busy(o_r_busy), .r_ack(o_r_ack), .init_done(o_init_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mm[i] = 8'hA5;
            mo[i] = 8'hA5;
        end
    endtask

    // Scoreboard: every read ack pops the oldest expectation of that channel.
    always @(negedge clock) begin
        if (m_r_ack[0]) begin
            if (mq0.size() == 0) fail("main_ack0_unexpected");
            else check("main_rdata0", 32'(m_r_data[7:0]), 32'(mq0.pop_front()));
        end
        if (m_r_ack[1]) begin
            if (mq1.size() == 0) fail("main_ack1_unexpected");
            else check("main_rdata1", 32'(m_r_data[15:8]), 32'(mq1.pop_front()));
        end
        if (o_r_ack[0]) begin
            if (oq0.size() == 0) fail("oor_ack0_unexpected");
            else check("oor_rdata0", 32'(o_r_data[7:0]), 32'(oq0.pop_front()));
        end
        if (o_r_ack[1]) begin
            if (oq1.size() == 0) fail("oor_ack1_unexpected");
            else check("oor_rdata1", 32'(o_r_data[15:8]), 32'(oq1.pop_front()));
        end
    end

    function automatic int pending();
        return mq0.size() + mq1.size() + oq0.size() + oq1.size();
    endfunction

    task automatic wait_drain();
        int k = 0;
        while (pending() != 0 && k < 50) begin
            step();
            k++;
        end
        if (pending() != 0) begin
            fail("read_ack_timeout");
            mq0.delete(); mq1.delete(); oq0.delete(); oq1.delete();
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        int k = 0;
        while (m_w_busy && k < 50) begin
            step();
            k++;
        end
        if (m_w_busy) fail("write_busy_timeout");
        w_req = 1'b1; w_addr = a; w_data = d;
        mm[a] = d;
        if (a < 4'd12) mo[a] = d;
        step();
        w_req = 1'b0;
        k = 0;
        while (!m_w_ack && k < 50) begin
            step();
            k++;
        end
        if (!m_w_ack) fail("write_ack_timeout");
        else check("oor_w_ack_align", 32'(o_w_ack), 32'd1);
    endtask

    task automatic do_reads(input logic [1:0] mask, input logic [3:0] a0, input logic [3:0] a1,
                            input logic [7:0] me0, input logic [7:0] me1,
                            input logic [7:0] oe0, input logic [7:0] oe1);
        int k = 0;
        while ((m_r_busy & mask) != 2'b00 && k < 50) begin
            step();
            k++;
        end
        if ((m_r_busy & mask) != 2'b00) fail("read_busy_timeout");
        r_req = mask;
        r_addr = {a1, a0};
        if (mask[0]) begin mq0.push_back(me0); oq0.push_back(oe0); end
        if (mask[1]) begin mq1.push_back(me1); oq1.push_back(oe1); end
        step();
        r_req = 2'b00;
        wait_drain();
    endtask

    task automatic do_reads_model(input logic [1:0] mask, input logic [3:0] a0, input logic [3:0] a1);
        do_reads(mask, a0, a1, mm[a0], mm[a1], mo[a0], mo[a1]);
    endtask

    task automatic sweep_window(input string tag);
        int acks = 0;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (m_w_ack) acks++;
            if (k == 12) check({tag, "_oor_init_12"}, 32'(o_init_done), 32'd0);
            if (k == 13) check({tag, "_oor_init_13"}, 32'(o_init_done), 32'd1);
            if (k == 16) check({tag, "_init_16"}, 32'(m_init_done), 32'd0);
            if (k == 17) check({tag, "_init_17"}, 32'(m_init_done), 32'd1);
            if (k == 5)  check({tag, "_wbusy_sweep"}, 32'(m_w_busy), 32'd1);
            if (k == 5)  check({tag, "_rbusy_sweep"}, 32'(m_r_busy), 32'd3);
            if (k == 10) begin w_req = 1'b0; r_req = 2'b00; end
        end
        check({tag, "_no_ack_in_sweep"}, 32'(acks), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] col_exp;
        logic [7:0] rd0, rd1;
        logic [1:0] rmask;
        int k;

        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b0, 2'b11, 4'(2*i), 4'(2*i+1), 8'h00, 8'hA5, 8'hA5};
        vecs[8]  = '{1'b1, 2'b00, 4'd1, 4'd0, 8'h11, 8'h00, 8'h00};
        vecs[9]  = '{1'b1, 2'b00, 4'd2, 4'd0, 8'h22, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 2'b00, 4'd7, 4'd0, 8'h5A, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 2'b01, 4'd7, 4'd0, 8'h00, 8'h5A, 8'h00};
        vecs[12] = '{1'b0, 2'b11, 4'd3, 4'd1, 8'h00, 8'hA5, 8'h11};
        vecs[13] = '{1'b0, 2'b10, 4'd0, 4'd2, 8'h00, 8'h00, 8'h22};
        model_reset();

        // Reset state
        repeat (3) step();
        check("rst_init_done", 32'(m_init_done), 32'd0);
        check("rst_w_ack", 32'(m_w_ack), 32'd0);
        check("rst_r_ack", 32'(m_r_ack), 32'd0);
        check("rst_r_data", 32'(m_r_data), 32'd0);
        check("rst_w_busy", 32'(m_w_busy), 32'd1);
        check("rst_r_busy", 32'(m_r_busy), 32'd3);

        // Init sweep with requests presented early; they must be ignored
        reset_n = 1'b1;
        w_req = 1'b1; w_addr = 4'd3; w_data = 8'h77;
        r_req = 2'b01; r_addr = 8'h03;
        sweep_window("sweep");

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) do_write(vecs[i].a0, vecs[i].data);
            else do_reads(vecs[i].mask, vecs[i].a0, vecs[i].a1,
                          vecs[i].e0, vecs[i].e1, vecs[i].e0, vecs[i].e1);
        end

        // Write timing: busy 3 cycles, ack on the 4th with busy low
        step();
        w_req = 1'b1; w_addr = 4'd4; w_data = 8'h3C;
        mm[4] = 8'h3C; mo[4] = 8'h3C;
        step(); w_req = 1'b0;
        check("wt_busy1", 32'(m_w_busy), 32'd1);
        step();
        check("wt_busy2", 32'(m_w_busy), 32'd1);
        step();
        check("wt_busy3", 32'(m_w_busy), 32'd1);
        check("wt_noack3", 32'(m_w_ack), 32'd0);
        step();
        check("wt_busy4", 32'(m_w_busy), 32'd0);
        check("wt_ack4", 32'(m_w_ack), 32'd1);
        step();
        check("wt_ack5", 32'(m_w_ack), 32'd0);
        do_reads_model(2'b01, 4'd4, 4'd0);

        // Request held through the ack cycle is accepted again
        w_req = 1'b1; w_addr = 4'd6; w_data = 8'h66;
        step(); w_data = 8'h67;
        step(); step(); step();
        check("hold_ack", 32'(m_w_ack), 32'd1);
        check("hold_busy_ack", 32'(m_w_busy), 32'd0);
        step();
        check("hold_reaccept_busy", 32'(m_w_busy), 32'd1);
        check("hold_reaccept_noack", 32'(m_w_ack), 32'd0);
        w_req = 1'b0;
        k = 0;
        while (!m_w_ack && k < 20) begin step(); k++; end
        if (!m_w_ack) fail("hold_second_ack_timeout");
        mm[6] = 8'h67; mo[6] = 8'h67;
        do_reads_model(2'b10, 4'd0, 4'd6);

        // Concurrent reads on both channels
        r_req = 2'b11; r_addr = {4'd2, 4'd1};
        mq0.push_back(8'h11); mq1.push_back(8'h22);
        oq0.push_back(8'h11); oq1.push_back(8'h22);
        step(); r_req = 2'b00;
        check("cc_noack1", 32'(m_r_ack), 32'd0);
        step();
        check("cc_noack2", 32'(m_r_ack), 32'd0);
        step();
        check("cc_ack3", 32'(m_r_ack), 32'd3);
        check("cc_data3", 32'(m_r_data), 32'h2211);
        step();
        check("cc_ack_pulse", 32'(m_r_ack), 32'd0);
        check("cc_data_hold", 32'(m_r_data), 32'h2211);
        wait_drain();

        // Same-edge write/read collision
        do_write(4'd5, 8'h00);
`ifdef MEMORY_MC_BYPASS_EN
        col_exp = 8'hFF;
`else
        col_exp = 8'h00;
`endif
        step();
        w_req = 1'b1; w_addr = 4'd5; w_data = 8'hFF;
        r_req = 2'b01; r_addr = {4'd0, 4'd5};
        mq0.push_back(col_exp); oq0.push_back(col_exp);
        mm[5] = 8'hFF; mo[5] = 8'hFF;
        step(); w_req = 1'b0; r_req = 2'b00;
        wait_drain();
        k = 0;
        while (m_w_busy && k < 20) begin step(); k++; end
        do_reads_model(2'b11, 4'd5, 4'd5);

        // Random traffic against the models
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end else begin
                rmask = 2'($urandom_range(1, 3));
                rd0 = 8'($urandom_range(0, 15));
                rd1 = 8'($urandom_range(0, 15));
                do_reads_model(rmask, rd0[3:0], rd1[3:0]);
            end
        end

        // Out of range on the 12-word instance
        do_write(4'd14, 8'h99);
        do_reads_model(2'b11, 4'd14, 4'd13);
        for (int a = 0; a < 12; a += 2)
            do_reads_model(2'b11, 4'(a), 4'(a + 1));

        // Reset in the middle of a write
        k = 0;
        while (m_w_busy && k < 20) begin step(); k++; end
        w_req = 1'b1; w_addr = 4'd9; w_data = 8'hC3;
        step(); w_req = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        check("mid_rst_init_done", 32'(m_init_done), 32'd0);
        check("mid_rst_w_ack", 32'(m_w_ack), 32'd0);
        check("mid_rst_r_data", 32'(m_r_data), 32'd0);
        reset_n = 1'b1;
        model_reset();
        sweep_window("resweep");
        do_reads_model(2'b11, 4'd9, 4'd4);

        wait_drain();
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_mc.md
Name: memory_mc

Overview:
- Parametrised successor to the team's single-port timed memory.
- One write channel and READ_CHANNELS independent read channels share one array.
- Each channel has its own programmable-latency request/ack handshake, and all channels run concurrently.
- On reset the block sweeps WORD_INIT into every word before accepting traffic; it sits between the controller FSMs and working storage.

Parameters:
WORD_SIZE, 8, data width in bits
WORD_INIT, 0, value written to every word during the init sweep
ADDRESS_SIZE, 4, address width
MEMORY_QTY, 16, number of words; must be <= 2**ADDRESS_SIZE
READ_CHANNELS, 2, number of independent read channels, >= 1
DELAY_SIZE, 4, width of the latency counters
READ_LATENCY, 1, read busy cycles, 1 .. 2**DELAY_SIZE-1
WRITE_LATENCY, 1, write busy cycles, 1 .. 2**DELAY_SIZE-1

Ports:
clock  in  1  single clock; all logic on rising edge
reset_n  in  1  reset, synchronous, active-low
w_req  in  1  write request
w_addr  in  ADDRESS_SIZE  write address
w_data  in  WORD_SIZE  write data
w_busy  out  1  write channel cannot accept
w_ack  out  1  one-cycle write-complete pulse
r_req  in  READ_CHANNELS  per-channel read request
r_addr  in  READ_CHANNELS*ADDRESS_SIZE  packed read addresses; channel c at [c*ADDRESS_SIZE +: ADDRESS_SIZE]
r_data  out  READ_CHANNELS*WORD_SIZE  packed read data, same packing
r_busy  out  READ_CHANNELS  per-channel busy
r_ack  out  READ_CHANNELS  per-channel one-cycle read-complete pulse
init_done  out  1  high once the init sweep has finished

Behaviour:
- Reset: reset_n low at a rising edge. init_done=0, w_ack=0, r_ack=0, r_data=0, all channel FSMs IDLE, sweep counter=0.
  - Reset mid-operation aborts all pending operations; no ack is issued for them.
- Init sweep:
  - On the first edge with reset_n high, write WORD_INIT at the counter address, then increment; one word per cycle.
  - After address MEMORY_QTY-1 is written, init_done=1 on the next edge. Sweep total = MEMORY_QTY cycles.
  - While init_done=0: w_busy=1, r_busy all 1, requests ignored (not queued).
- Write FSM states: W_IDLE, W_WAIT. w_busy = (state==W_WAIT) | ~init_done.
  - W_IDLE with w_req=1: accept. mem[w_addr] <= w_data on the accept edge; counter <= WRITE_LATENCY-1; go to W_WAIT.
  - W_WAIT: if counter==0, go to W_IDLE and w_ack <= 1; else decrement the counter.
  - Timing: busy for exactly WRITE_LATENCY cycles, then a w_ack pulse in the following cycle; busy is low in the ack cycle.
  - A new request present in the ack cycle is accepted at that cycle's closing edge. Peak rate: one write per WRITE_LATENCY+1 cycles.
- Read FSM, per channel c, identical and independent. States: R_IDLE, R_WAIT.
  - R_IDLE with r_req[c]=1: accept. Snapshot mem[r_addr_c] into a holding register on the accept edge; counter <= READ_LATENCY-1.
  - R_WAIT: same countdown as the write FSM. On exit, r_data_c <= snapshot and r_ack[c] <= 1.
  - r_data_c holds until that channel's next ack.
- Collisions:
  - A read accepted on the same edge as a write to the same address returns the OLD word (see Optional Feature).
  - Any number of channels may read the same address in the same cycle.
- Out of range (address >= MEMORY_QTY):
  - Write is dropped, but busy/ack timing is unchanged.
  - Read returns WORD_INIT with normal timing.
- Requests held high past acceptance are ignored while busy. A request still high in the ack cycle is accepted again as a new operation.

Optional Feature:
- Macro: MEMORY_MC_BYPASS_EN.
- Defined: a read accepted on the same edge as an accepted write to the same in-range address snapshots w_data (new value).
- Undefined: the read returns the old contents. Latency is unaffected in both cases.

Test Plan:
- Init sweep (MEMORY_QTY=16, WORD_INIT=8'hA5): release reset → init_done rises exactly 17 edges after release; reading addresses 0..15 returns 8'hA5.
- Write timing (WRITE_LATENCY=3): w_req with addr 4, data 8'h3C accepted → w_busy high 3 cycles; w_ack pulses 1 cycle on the 4th; channel 0 then reads 8'h3C from address 4.
- Concurrent reads (READ_LATENCY=2, 2 channels, mem[1]=8'h11, mem[2]=8'h22): both channels request in the same cycle → both r_ack pulse on the same later cycle; r_data = {8'h22, 8'h11}.
- Collision (mem[5]=8'h00): write 8'hFF to address 5 and channel 0 reads address 5 on the same edge → r_data_0 = 8'h00 without the macro, 8'hFF with MEMORY_MC_BYPASS_EN.
- Reset mid-write: drop reset_n during W_WAIT → no w_ack; init_done=0; a full sweep reruns; the target word equals WORD_INIT.
- Out of range (MEMORY_QTY=12): write address 14 → w_ack arrives with normal timing; a read of address 14 returns WORD_INIT; no in-range word changes.
